// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch-address generator feeding the IF stage. Holds PCF and
//            selects the next fetch PC from the sequential PCPlus4F, the EX
//            redirect target or the trap vector. Sequences the imem boot
//            warm-up, stall hold, and a halt on a misaligned redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              BOOT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            TrapE,
  input  logic [XLEN-1:0] TrapVec,
  input  logic [XLEN-1:0] PCPlus4F,
  output logic [XLEN-1:0] PCF,
  output logic            FetchValidF,
  output logic            MisalignF,
  output logic [XLEN-1:0] MisalignAddrF
);

  localparam int              CNT_W       = $clog2(BOOT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_BOOT_INIT = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [XLEN-1:0]  C_ALIGN_MSK = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  bootcnt_q;
  logic [XLEN-1:0]   pcf_q;
  logic              valid_q;
  logic              misalign_q;
  logic [XLEN-1:0]   misaddr_q;

  // Trap vector low bits are not addressable; a redirect target is only
  // legal when word aligned.
  logic [XLEN-1:0]   w_trap_pc;
  logic              w_tgt_misaligned;

  assign w_trap_pc        = TrapVec & C_ALIGN_MSK;
  assign w_tgt_misaligned = |PCTargetE[1:0];

  // Boot/run/halt sequencer with next-PC selection and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      bootcnt_q  <= C_BOOT_INIT;
      pcf_q      <= RESET_VEC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      misaddr_q  <= '0;
    end else begin
      // The misalign flag is a single-cycle pulse; only the RUN branch re-raises it.
      misalign_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          // Redirects and stalls are meaningless while imem warms up.
          if (bootcnt_q == '0) begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
          end else begin
            bootcnt_q <= bootcnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (TrapE) begin
            pcf_q <= w_trap_pc;
          end else if (PCSrcE && !w_tgt_misaligned) begin
            // A redirect flushes any stalled fetch, so StallF loses here.
            pcf_q <= PCTargetE;
          end else if (PCSrcE) begin
            misalign_q <= 1'b1;
            misaddr_q  <= PCTargetE;
            state_q    <= ST_HALT;
            valid_q    <= 1'b0;
          end else if (!StallF) begin
            pcf_q <= PCPlus4F;
          end
        end
        ST_HALT: begin
          // Only a trap can restart fetching after a misaligned redirect.
          if (TrapE) begin
            pcf_q   <= w_trap_pc;
            state_q <= ST_RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign PCF           = pcf_q;
  assign FetchValidF   = valid_q;
  assign MisalignF     = misalign_q;
  assign MisalignAddrF = misaddr_q;

  // The fetch PC must stay word aligned whenever reset is not active.
  a_pcf_aligned: assert property (@(posedge clk) disable iff (reset) (pcf_q[1:0] == 2'b00));

endmodule
`default_nettype wire
